// File: rtl/pc_seq_pkg.sv
// Shared encodings and helpers for the PC sequencer.
package pc_seq_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  // Branch-condition selector as produced by the decode controller
  localparam logic [2:0] BC_EQ     = 3'b000;
  localparam logic [2:0] BC_NE     = 3'b101;
  localparam logic [2:0] BC_LEZ    = 3'b011;
  localparam logic [2:0] BC_GTZ    = 3'b010;
  localparam logic [2:0] BC_REGIMM = 3'b001;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  // Word-offset branch target, modulo 2^32
  function automatic logic [INSTR_W-1:0] branch_target(input logic [INSTR_W-1:0] pc4,
                                                       input logic [INSTR_W-1:0] off);
    return pc4 + (off << 2);
  endfunction

endpackage

// File: rtl/pc_sequencer_branch_cond_eval.sv
// Combinational branch-condition evaluator (signed compares on rs/rt).
module branch_cond_eval
  import pc_seq_pkg::*;
(
  input  logic [2:0]         BCControl,
  input  logic               BranchSourceMux,
  input  logic [4:0]         RtField,
  input  logic [INSTR_W-1:0] RsData,
  input  logic [INSTR_W-1:0] RtData,
  output logic               cond
);

  logic rs_neg, rs_zero, regimm_cond;
  logic unused_rt_hi;

  assign rs_neg  = RsData[INSTR_W-1];
  assign rs_zero = (RsData == '0);

  // REGIMM: bit 0 of rt selects BGEZ (1) or BLTZ (0); only valid when the
  // decoder says the condition is sourced from the rt field.
  assign regimm_cond  = BranchSourceMux & (RtField[0] ? ~rs_neg : rs_neg);
  assign unused_rt_hi = ^RtField[4:1];

  // Select the condition; unknown encodings are never taken
  always_comb begin
    cond = 1'b0;
    case (BCControl)
      BC_EQ:     cond = (RsData == RtData);
      BC_NE:     cond = (RsData != RtData);
      BC_LEZ:    cond = rs_neg | rs_zero;
      BC_GTZ:    cond = ~rs_neg & ~rs_zero;
      BC_REGIMM: cond = regimm_cond;
      default:   cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: owns the fetch PC, resolves branches/jumps in ID, drives
// the IF/ID enable/flush. Optional branch statistics under
// PC_SEQ_BRANCH_STATS_EN (adds TakenCount / NotTakenCount outputs).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BOOT_CYCLES  = 1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Branch,
  input  logic               Jump,
  input  logic               JumpMux,
  input  logic [2:0]         BCControl,
  input  logic               BranchSourceMux,
  input  logic [4:0]         RtField,
  input  logic [INSTR_W-1:0] RsData,
  input  logic [INSTR_W-1:0] RtData,
  input  logic [INSTR_W-1:0] BranchOffset,
  input  logic [25:0]        JumpTarget,
  input  logic [INSTR_W-1:0] IdPCPlus4,
  input  logic               StallReq,
  output logic [INSTR_W-1:0] PC,
  output logic [INSTR_W-1:0] PCPlus4,
  output logic               IFID_WriteEnable,
  output logic               IFID_Flush,
  output logic               Redirect,
  output logic               AddrFault
`ifdef PC_SEQ_BRANCH_STATS_EN
  ,
  output logic [31:0]        TakenCount,
  output logic [31:0]        NotTakenCount
`endif
);

  state_t             state;
  logic [3:0]         boot_cnt;
  logic [INSTR_W-1:0] pc_q, pc_next, target;
  logic               cond, active, jump_go, br_eval, br_go, redirect, jr_bad;

  branch_cond_eval u_cond (
    .BCControl       (BCControl),
    .BranchSourceMux (BranchSourceMux),
    .RtField         (RtField),
    .RsData          (RsData),
    .RtData          (RtData),
    .cond            (cond)
  );

  // ID is evaluated whenever out of boot and not stalled; STALL with the
  // request already dropped behaves as RUN in that same cycle.
  assign active   = (state != ST_BOOT) & ~StallReq;
  assign jump_go  = active & Jump;
  assign br_eval  = active & Branch & ~Jump;
  assign br_go    = br_eval & cond;
  assign redirect = jump_go | br_go;
  assign jr_bad   = jump_go & JumpMux & (RsData[1:0] != 2'b00);

  // Redirect target; jumps win over branches, JR targets are word-aligned
  always_comb begin
    target = branch_target(IdPCPlus4, BranchOffset);
    if (Jump) begin
      if (JumpMux) target = {RsData[INSTR_W-1:2], 2'b00};
      else         target = {IdPCPlus4[31:28], JumpTarget, 2'b00};
    end
  end

  // Next fetch address: redirect, sequential, or hold
  always_comb begin
    pc_next = pc_q;
    if (redirect)    pc_next = target;
    else if (active) pc_next = pc_q + PC_INC;
  end

  // Sequencer state, boot counter and PC
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= ST_BOOT;
      boot_cnt <= 4'(BOOT_CYCLES - 1);
      pc_q     <= RESET_VECTOR;
    end else begin
      case (state)
        ST_BOOT: begin
          if (boot_cnt == 4'd0) state <= ST_RUN;
          else                  boot_cnt <= boot_cnt - 4'd1;
        end
        ST_RUN, ST_STALL: begin
          state <= StallReq ? ST_STALL : ST_RUN;
          pc_q  <= pc_next;
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

  assign PC               = pc_q;
  assign PCPlus4          = pc_q + PC_INC;
  assign IFID_WriteEnable = active;
  assign IFID_Flush       = (state == ST_BOOT) | redirect;
  assign Redirect         = redirect;
  assign AddrFault        = jr_bad;

`ifdef PC_SEQ_BRANCH_STATS_EN
  // Saturating taken / not-taken branch counters (jumps excluded)
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      TakenCount    <= '0;
      NotTakenCount <= '0;
    end else begin
      if (br_go && TakenCount != 32'hFFFF_FFFF)
        TakenCount <= TakenCount + 32'd1;
      if (br_eval && !cond && NotTakenCount != 32'hFFFF_FFFF)
        NotTakenCount <= NotTakenCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer (RESET_VECTOR=0x100, BOOT_CYCLES=2).
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch, jump, jump_mux, bsm, stall;
  logic [2:0]  bcc;
  logic [4:0]  rt_field;
  logic [31:0] rs, rt, off, id_pc4;
  logic [25:0] jt;
  logic [31:0] pc, pc_plus4;
  logic        we, flush, redir, fault;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        we, fl, rd, af;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(32'h100), .BOOT_CYCLES(2)) dut (
    .Clock(clk), .Reset(rst), .Branch(branch), .Jump(jump), .JumpMux(jump_mux),
    .BCControl(bcc), .BranchSourceMux(bsm), .RtField(rt_field), .RsData(rs),
    .RtData(rt), .BranchOffset(off), .JumpTarget(jt), .IdPCPlus4(id_pc4),
    .StallReq(stall), .PC(pc), .PCPlus4(pc_plus4), .IFID_WriteEnable(we),
    .IFID_Flush(flush), .Redirect(redir), .AddrFault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic push(input string tag, input logic [31:0] p,
                      input logic w, input logic f, input logic r, input logic a);
    exp_t e;
    e.tag = tag; e.pc = p; e.we = w; e.fl = f; e.rd = r; e.af = a;
    exp_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare against current DUT outputs
  task automatic pop_cmp();
    exp_t e;
    e = exp_q.pop_front();
    chk({e.tag, ".pc"},    pc,             e.pc);
    chk({e.tag, ".pc4"},   pc_plus4,       e.pc + 32'd4);
    chk({e.tag, ".we"},    {31'd0, we},    {31'd0, e.we});
    chk({e.tag, ".flush"}, {31'd0, flush}, {31'd0, e.fl});
    chk({e.tag, ".redir"}, {31'd0, redir}, {31'd0, e.rd});
    chk({e.tag, ".fault"}, {31'd0, fault}, {31'd0, e.af});
  endtask

  // One cycle: inputs already driven; sample at negedge, then advance
  task automatic cyc(input string tag, input logic [31:0] p,
                     input logic w, input logic f, input logic r, input logic a);
    push(tag, p, w, f, r, a);
    @(negedge clk);
    pop_cmp();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    branch = 0; jump = 0; jump_mux = 0; bsm = 0; stall = 0;
    bcc = 3'b111; rt_field = 0; rs = 0; rt = 0; off = 0; id_pc4 = 0; jt = 0;
  endtask

  task automatic set_br(input logic [2:0] c, input logic s, input logic [4:0] rf,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ipc4, input logic [31:0] o);
    idle();
    branch = 1; bcc = c; bsm = s; rt_field = rf; rs = a; rt = b; id_pc4 = ipc4; off = o;
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    push("reset", 32'h100, 0, 1, 0, 0); pop_cmp();
    rst = 0;
    // boot: two flushed cycles, then sequential fetch
    cyc("boot0", 32'h100, 0, 1, 0, 0);
    cyc("boot1", 32'h100, 0, 1, 0, 0);
    cyc("run0",  32'h100, 1, 0, 0, 0);
    cyc("run1",  32'h104, 1, 0, 0, 0);
    // BEQ taken -> 0x40 + 12
    set_br(BC_EQ, 0, 0, 5, 5, 32'h40, 3);
    cyc("beq_t", 32'h108, 1, 1, 1, 0);
    set_br(BC_EQ, 0, 0, 5, 6, 32'h40, 3);
    cyc("beq_nt", 32'h4C, 1, 0, 0, 0);
    // BLTZ taken, offset -4 -> 0x200 - 16
    set_br(BC_REGIMM, 1, 5'b00000, 32'hFFFF_FFFF, 0, 32'h200, 32'hFFFF_FFFC);
    cyc("bltz_t", 32'h50, 1, 1, 1, 0);
    set_br(BC_REGIMM, 1, 5'b00001, 32'hFFFF_FFFF, 0, 32'h200, 32'h10);
    cyc("bgez_nt", 32'h1F0, 1, 0, 0, 0);
    set_br(BC_LEZ, 0, 0, 0, 0, 32'h300, 32'h10);
    cyc("blez_t", 32'h1F4, 1, 1, 1, 0);
    set_br(BC_GTZ, 0, 0, 0, 0, 32'h300, 32'h10);
    cyc("bgtz_nt", 32'h340, 1, 0, 0, 0);
    // BNE with target wrapping past the top of the address space
    set_br(BC_NE, 0, 0, 1, 2, 32'hFFFF_FFF0, 8);
    cyc("bne_wrap", 32'h344, 1, 1, 1, 0);
    set_br(3'b111, 0, 0, 7, 7, 32'h500, 8);
    cyc("bc_undef", 32'h10, 1, 0, 0, 0);
    // JR misaligned
    idle(); jump = 1; jump_mux = 1; rs = 32'h0000_2002;
    cyc("jr_bad", 32'h14, 1, 1, 1, 1);
    // J region jump
    idle(); jump = 1; jt = 26'h10; id_pc4 = 32'h3000_0000;
    cyc("j", 32'h2000, 1, 1, 1, 0);
    // Jump and taken branch together: jump wins
    set_br(BC_EQ, 0, 0, 1, 1, 32'h5000_0000, 1);
    jump = 1; jt = 26'h10;
    cyc("j_prio", 32'h3000_0040, 1, 1, 1, 0);
    // Stall with a taken branch pending
    set_br(BC_EQ, 0, 0, 9, 9, 32'h800, 2);
    stall = 1;
    cyc("stall0", 32'h5000_0040, 0, 0, 0, 0);
    cyc("stall1", 32'h5000_0040, 0, 0, 0, 0);
    stall = 0;
    cyc("unstall", 32'h5000_0040, 1, 1, 1, 0);
    // JR to the last word, then PC+4 wraps to 0
    idle(); jump = 1; jump_mux = 1; rs = 32'hFFFF_FFFC;
    cyc("jr_top", 32'h808, 1, 1, 1, 0);
    idle();
    cyc("pc_top", 32'hFFFF_FFFC, 1, 0, 0, 0);
    cyc("pc_wrap", 32'h0, 1, 0, 0, 0);
    // Reset pulse landing on a redirect cycle
    set_br(BC_EQ, 0, 0, 3, 3, 32'h900, 4);
    #1;
    push("pre_rst", 32'h4, 1, 1, 1, 0); pop_cmp();
    rst = 1;
    #1;
    push("mid_rst", 32'h100, 0, 1, 0, 0); pop_cmp();
    @(posedge clk); #1;
    rst = 0;
    cyc("reboot0", 32'h100, 0, 1, 0, 0);
    cyc("reboot1", 32'h100, 0, 1, 0, 0);
    idle();
    cyc("rerun0", 32'h100, 1, 0, 0, 0);
    cyc("rerun1", 32'h104, 1, 0, 0, 0);
    if (exp_q.size() != 0) chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
